gerador_codigo: RTL and testbench

Upstream code sequencer for the 5-bit-to-7-segment decoder: produces the 5-bit symbol code (0..MAX_CODE) that drives the decoder's input. It steps automatically at a prescaled rate, supports pause/run and up/down direction via two raw pushbuttons, and accepts an explicit code load over a valid/ready handshake. Its `codigo` output connects directly to the decoder input; `passo` marks every code change.

---
 rtl/gerador_codigo.sv | 227 ++++++++++++++++++++++
 tb/tb_gerador_codigo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerador_codigo.sv
// gerador_codigo: code sequencer feeding the 5-bit-to-7-segment decoder.
// Steps `codigo` through 0..MAX_CODE at a prescaled rate. Two raw
// pushbuttons toggle run/pause and up/down. A valid/ready port loads an
// explicit code.
// Optional feature macro: GERADOR_DEBOUNCE_EN. When it is defined, each
// button gets a debounce counter. When it is undefined, the filtered
// level is simply the synchronized level.
// Debug: `estado` mirrors the FSM state (0 = PAUSA, 1 = RODA, 2 = CARREGA).

module gerador_codigo #(
  parameter int PRESCALE        = 50_000_000,
  parameter int MAX_CODE        = 19,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_pausa,
  input  logic       btn_sentido,
  input  logic       carga_valida,
  input  logic [4:0] carga_dado,
  output logic       carga_pronta,
  output logic [4:0] codigo,
  output logic       passo,
  output logic       rodando,
  output logic       desce,
  output logic       erro_carga,
  output logic [1:0] estado
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [4:0]      MAX_C    = 5'(MAX_CODE);

  typedef enum logic [1:0] {
    PAUSA   = 2'd0,
    RODA    = 2'd1,
    CARREGA = 2'd2
  } estado_t;

  estado_t         st;
  estado_t         ret;
  logic [PW-1:0]   pre;

  // ---------------------------------------------------------------------
  // Button conditioning: bit 0 = pausa, bit 1 = sentido.
  // raw -> sync1 -> sync2 -> nivel (filtered) -> nivel_q (edge detect).
  // ---------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] nivel;
  logic [1:0] nivel_q;
  logic [1:0] evento;

  assign btn_raw = {btn_sentido, btn_pausa};

  // Two-flop synchronizer for the asynchronous pushbuttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef GERADOR_DEBOUNCE_EN
  localparam int            DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES);

  logic [DW-1:0] cnt [2];

  // The level follows the input only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement. Any cycle of agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != nivel[i]) begin
          if (cnt[i] == DEB_LAST) begin
            nivel[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + DW'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  // No filtering: register the synchronized level directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel <= '0;
    end else begin
      nivel <= sync2;
    end
  end
`endif

  // Previous filtered level, used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel_q <= '0;
    end else begin
      nivel_q <= nivel;
    end
  end

  // A rising edge of the filtered level lasts exactly one cycle.
  assign evento = nivel & ~nivel_q;

  logic pausa_ev;
  logic sentido_ev;

  assign pausa_ev   = evento[0];
  assign sentido_ev = evento[1];

  // ---------------------------------------------------------------------
  // Load handshake (valid/ready):
  //   A transfer happens on a rising edge where carga_valida and
  //   carga_pronta are both high. carga_valida may be held across cycles.
  //   carga_pronta is registered. It is low only while in CARREGA, so
  //   transfers can occur at most every second cycle.
  // ---------------------------------------------------------------------
  logic       transfer;
  logic       carga_ok;
  logic [4:0] carga_val;

  assign transfer  = carga_valida & carga_pronta;
  assign carga_ok  = (carga_dado <= MAX_C);
  assign carga_val = carga_ok ? carga_dado : 5'd0;

  // The toggle helper swaps PAUSA and RODA. CARREGA never appears as an argument.
  function automatic estado_t alterna(input estado_t s);
    return (s == RODA) ? PAUSA : RODA;
  endfunction

  // Next code in the chosen direction, wrapping within 0..MAX_CODE.
  function automatic logic [4:0] proximo(input logic [4:0] c, input logic d);
    if (d) begin
      return (c == 5'd0) ? MAX_C : (c - 5'd1);
    end else begin
      return (c >= MAX_C) ? 5'd0 : (c + 5'd1);
    end
  endfunction

  // A pausa event that coincides with a load, or arrives during CARREGA,
  // is applied to the state the load returns to.
  estado_t ret_alvo;
  estado_t ret_novo;

  assign ret_alvo = pausa_ev ? alterna(ret) : ret;
  assign ret_novo = pausa_ev ? alterna(st) : st;

  // Main FSM: state, prescaler, code and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= PAUSA;
      ret          <= PAUSA;
      pre          <= '0;
      codigo       <= 5'd0;
      desce        <= 1'b0;
      passo        <= 1'b0;
      erro_carga   <= 1'b0;
      rodando      <= 1'b0;
      carga_pronta <= 1'b1;
    end else begin
      passo      <= 1'b0;
      erro_carga <= 1'b0;

      // Any step taken in this same cycle still reads the old direction.
      if (sentido_ev) begin
        desce <= ~desce;
      end

      case (st)
        CARREGA: begin
          st           <= ret_alvo;
          rodando      <= (ret_alvo == RODA);
          carga_pronta <= 1'b1;
          pre          <= '0;
        end

        default: begin
          if (transfer) begin
            // A load takes priority over a prescaler wrap in the same cycle.
            ret          <= ret_novo;
            st           <= CARREGA;
            rodando      <= 1'b0;
            carga_pronta <= 1'b0;
            pre          <= '0;
            codigo       <= carga_val;
            passo        <= (carga_val != codigo);
            erro_carga   <= ~carga_ok;
          end else if (st == RODA) begin
            if (pre == PRE_LAST) begin
              pre    <= '0;
              codigo <= proximo(codigo, desce);
              passo  <= 1'b1;
            end else begin
              pre <= pre + PW'(1);
            end
            // A pause that coincides with a step still lets the step happen.
            if (pausa_ev) begin
              st      <= PAUSA;
              rodando <= 1'b0;
            end
          end else if (pausa_ev) begin
            st      <= RODA;
            rodando <= 1'b1;
          end
        end
      endcase
    end
  end

  assign estado = st;

endmodule

// File: tb/tb_gerador_codigo.sv
// Bench for gerador_codigo (PRESCALE=4, MAX_CODE=19, DEBOUNCE_CYCLES=3).
// A stimulus process pushes {cycle, code} expectations computed from a
// modulo-arithmetic model. A monitor pops one entry on every passo pulse.

module tb_gerador_codigo;

  localparam int PRESCALE = 4;
  localparam int MAX_CODE = 19;
  localparam int DEB      = 3;
`ifdef GERADOR_DEBOUNCE_EN
  localparam int BTN_LAT  = DEB + 3;
`else
  localparam int BTN_LAT  = 3;
`endif

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b1;
  logic       btn_pausa    = 1'b0;
  logic       btn_sentido  = 1'b0;
  logic       carga_valida = 1'b0;
  logic [4:0] carga_dado   = 5'd0;
  logic       carga_pronta;
  logic [4:0] codigo;
  logic       passo;
  logic       rodando;
  logic       desce;
  logic       erro_carga;
  logic [1:0] estado;

  gerador_codigo #(
    .PRESCALE        (PRESCALE),
    .MAX_CODE        (MAX_CODE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_pausa    (btn_pausa),
    .btn_sentido  (btn_sentido),
    .carga_valida (carga_valida),
    .carga_dado   (carga_dado),
    .carga_pronta (carga_pronta),
    .codigo       (codigo),
    .passo        (passo),
    .rodando      (rodando),
    .desce        (desce),
    .erro_carga   (erro_carga),
    .estado       (estado)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q[$];   // {cycle[31:0], code[4:0]}
  int n_tests   = 0;
  int n_fail    = 0;
  int erro_seen = 0;
  int erro_exp  = 0;

  // Reference model: current code, direction, last step/entry cycle, pending toggle
  int m_code = 0;
  bit m_down = 1'b0;
  int m_last = 0;
  int m_tog  = -1;

  function automatic int ref_step(input int c, input bit d);
    return d ? (c + MAX_CODE) % (MAX_CODE + 1) : (c + 1) % (MAX_CODE + 1);
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (passo) begin
        if (exp_q.size() == 0) begin
          check("passo_unexpected", 1, 0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          check("step_code", int'(codigo), int'(e[4:0]));
          check("step_cycle", cyc, int'(e[36:5]));
        end
      end
      if (erro_carga) erro_seen++;
      if (codigo > 5'(MAX_CODE)) check("code_range", int'(codigo), MAX_CODE);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("schedule", cyc, target);
  endtask

  task automatic run_steps(input int n);
    for (int k = 0; k < n; k++) begin
      int nc;
      nc = m_last + PRESCALE;
      if (m_tog >= 0 && m_tog < nc) begin
        m_down = ~m_down;
        m_tog  = -1;
      end
      m_code = ref_step(m_code, m_down);
      exp_q.push_back({32'(nc), 5'(m_code)});
      m_last = nc;
      wait_until(nc);
    end
  endtask

  task automatic press_pausa(output int tog);
    btn_pausa = 1'b1;
    tog = cyc + 1 + BTN_LAT;
    fork
      begin
        repeat (10) @(negedge clk);
        btn_pausa = 1'b0;
      end
    join_none
  endtask

  task automatic press_sentido(output int tog);
    btn_sentido = 1'b1;
    tog = cyc + 1 + BTN_LAT;
    fork
      begin
        repeat (10) @(negedge clk);
        btn_sentido = 1'b0;
      end
    join_none
  endtask

  task automatic do_load(input int dado, input int r);
    int l;
    int nv;
    wait_until(m_last + r);
    l  = cyc + 1;
    nv = (dado <= MAX_CODE) ? dado : 0;
    carga_dado   = 5'(dado);
    carga_valida = 1'b1;
    if (nv != m_code) exp_q.push_back({32'(l), 5'(nv)});
    if (dado > MAX_CODE) erro_exp++;
    m_code = nv;
    @(negedge clk);
    carga_valida = 1'b0;
    check("load_code", int'(codigo), nv);
    check("load_pronta_low", int'(carga_pronta), 0);
    check("load_erro", int'(erro_carga), (dado > MAX_CODE) ? 1 : 0);
    @(negedge clk);
    check("load_pronta_back", int'(carga_pronta), 1);
    check("load_erro_pulse", int'(erro_carga), 0);
    m_last = l + 1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int tog;
    int held;
    int l;
    #1 rst_n = 1'b0;
    #2;
    check("rst_codigo", int'(codigo), 0);
    check("rst_passo", int'(passo), 0);
    check("rst_rodando", int'(rodando), 0);
    check("rst_desce", int'(desce), 0);
    check("rst_erro", int'(erro_carga), 0);
    check("rst_pronta", int'(carga_pronta), 1);
    check("rst_estado", int'(estado), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_codigo", int'(codigo), 0);
    check("idle_rodando", int'(rodando), 0);

    // Start running: latency from press to rodando
    press_pausa(tog);
    wait_until(tog - 1);
    check("pausa_lat_before", int'(rodando), 0);
    wait_until(tog);
    check("pausa_lat_rodando", int'(rodando), 1);
    check("pausa_lat_estado", int'(estado), 1);
    m_last = tog;

    // Count up through the 19 -> 0 wrap, then reverse direction
    run_steps(19);
    press_sentido(tog);
    m_tog = tog;
    run_steps(3);
    check("desce_set", int'(desce), 1);
    press_sentido(tog);
    m_tog = tog;
    run_steps(2);
    check("desce_clear", int'(desce), 0);

    // Load 7 on the prescaler wrap edge: load wins, next step gives 8
    do_load(7, 3);
    run_steps(1);

    // Out-of-range load
    do_load(25, 0);
    run_steps(1);

    // Back-to-back: reload same code (no passo), then 3 two cycles later
    wait_until(m_last);
    l = cyc + 1;
    carga_dado   = 5'(m_code);
    carga_valida = 1'b1;
    @(negedge clk);
    check("b2b_same_code", int'(codigo), m_code);
    check("b2b_pronta_low", int'(carga_pronta), 0);
    carga_dado = 5'd3;
    @(negedge clk);
    check("b2b_pronta_high", int'(carga_pronta), 1);
    check("b2b_hold_code", int'(codigo), m_code);
    if (m_code != 3) exp_q.push_back({32'(l + 2), 5'd3});
    m_code = 3;
    @(negedge clk);
    carga_valida = 1'b0;
    check("b2b_second", int'(codigo), 3);
    m_last = l + 3;
    run_steps(1);

    // Pause, idle, resume; pre is held across the pause
    press_pausa(tog);
    while (m_last + PRESCALE <= tog) run_steps(1);
    wait_until(tog);
    check("pause_rodando", int'(rodando), 0);
    check("pause_estado", int'(estado), 0);
    held = (tog - m_last) % PRESCALE;
`ifdef GERADOR_DEBOUNCE_EN
    repeat (12) @(negedge clk);
    repeat (4) begin
      btn_pausa = 1'b1;
      repeat (2) @(negedge clk);
      btn_pausa = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("glitch_rodando", int'(rodando), 0);
`else
    repeat (12) @(negedge clk);
`endif
    check("pause_code_held", int'(codigo), m_code);
    press_pausa(tog);
    wait_until(tog);
    check("resume_rodando", int'(rodando), 1);
    m_last = tog - held;
    run_steps(2);

    // Randomized loads at random prescaler phases
    repeat (12) begin
      do_load($urandom_range(0, 31), $urandom_range(0, 3));
      run_steps($urandom_range(0, 2));
    end

    // Asynchronous reset mid-count at code 12
    do_load(12, 1);
    repeat (2) @(negedge clk);
    check("pre_reset_code", int'(codigo), 12);
    #2 rst_n = 1'b0;
    #1;
    check("arst_codigo", int'(codigo), 0);
    check("arst_rodando", int'(rodando), 0);
    check("arst_estado", int'(estado), 0);
    check("arst_desce", int'(desce), 0);
    check("arst_pronta", int'(carga_pronta), 1);
    check("arst_passo", int'(passo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_code", int'(codigo), 0);
    check("post_rst_rodando", int'(rodando), 0);

    check("queue_drained", exp_q.size(), 0);
    check("erro_count", erro_seen, erro_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
